dvp_frame_tx: RTL and testbench
===============================

// Module: dvp_frame_tx
// PURPOSE
//  Camera-side DVP (OV-style parallel) byte-stream transmitter: drives pclk/vsync/href/data
//  into a camera receive port. Serves as an on-board camera emulator for bring-up without a sensor.
//  Bytes come from a valid/ready stream; all frame timing is generated internally.
//  Sits between a pixel source (FIFO, SPI-loaded buffer) and the cam_* pins of a receiving design.
// PARAMETERS
//  CLK_DIV      4    clk cycles per output byte period; even, >=2
//  H_ACTIVE     160  bytes per active line (href high)
//  H_BLANK      16   byte periods of href low after each active line
//  ROWS         120  active lines per frame
//  VSYNC_LINES  3    line periods with vsync high at frame start
//  V_BACK       2    blank line periods after vsync
//  V_FRONT      2    blank line periods after last active line
//  CONTINUOUS   0    1: restart the next frame immediately after V_FRONT, with no IDLE gap
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high
//  start       in   1  pulse: begin one frame (ignored while busy)
//  s_data      in   8  source byte
//  s_valid     in   1  source byte valid
//  s_ready     out  1  one-cycle accept strobe (see BEHAVIOUR)
//  cam_pclk    out  1  pixel clock; data is stable around its rising edge
//  cam_vsync   out  1  frame sync, active high
//  cam_href    out  1  line valid, active high
//  cam_dat     out  8  pixel byte
//  busy        out  1  high from start accept until frame end
//  underflow   out  1  sticky: a byte slot found s_valid low; cleared by start accept or reset
//  frame_done  out  1  one-cycle pulse in the cycle the FSM leaves VFRONT
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE. Reset mid-frame aborts immediately; there is no flush.
//  Byte timer: period = CLK_DIV cycles; phase counter 0..CLK_DIV-1.
//   - cam_pclk = 0 for phases 0..CLK_DIV/2-1, and 1 otherwise. It is registered and runs only while busy.
//   - cam_dat, cam_href and cam_vsync update only at phase 0, so they are held across the pclk rise.
//  Counters: line = H_ACTIVE+H_BLANK byte periods; col counter wraps per line, row counter per state.
//  FSM states and transitions:
//   - IDLE -> VSYNC on start (or on frame end when CONTINUOUS=1).
//   - VSYNC (VSYNC_LINES lines) -> VBACK (V_BACK lines) -> ACTIVE (ROWS lines) -> VFRONT (V_FRONT lines) -> IDLE.
//   - A zero-length VBACK or VFRONT is skipped.
//  Signal levels:
//   - cam_vsync = 1 only in VSYNC.
//   - cam_href = 1 in ACTIVE while col < H_ACTIVE.
//   - cam_dat = 0 whenever href = 0.
//  Byte fetch, in each href-high byte period at phase 0:
//   - s_ready = 1 for that single cycle.
//   - If s_valid: cam_dat <= s_data. Else: cam_dat <= 8'h00, underflow <= 1.
//   - The frame does not stall; the timing grid is fixed.
//  s_ready is never asserted outside href-high phase-0 cycles. Exactly H_ACTIVE*ROWS strobes per frame.
//  start while busy: ignored. start in the same cycle as frame_done with CONTINUOUS=0: ignored.
//  busy falls in the cycle after frame_done.
//  Frame length = (VSYNC_LINES+V_BACK+ROWS+V_FRONT)*(H_ACTIVE+H_BLANK)*CLK_DIV cycles.
// CONFIGURATION
//  DVP_TX_TEST_PATTERN_EN
//   - Defined: adds input tp_sel (1 bit), sampled at start accept.
//   - When tp_sel=1: source bytes = 8-bit counter cleared each frame, +1 per byte slot.
//   - In pattern mode s_ready stays 0, s_valid is ignored, and underflow never sets.
//   - Not defined: no tp_sel port; stream-only behaviour as above.
// TESTING
//  Common params: CLK_DIV=2, H_ACTIVE=4, H_BLANK=2, ROWS=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1.
//  Frame = 30 byte periods = 60 clk cycles.
//  1. Reset, then start pulse, s_valid=1, s_data=A0,A1,...
//     -> vsync high for 12 clk; href high for 8 clk twice.
//     -> cam_dat = A0..A3 then A4..A7.
//     -> frame_done exactly 60 clk after start accept; underflow=0.
//  2. s_valid low during the 3rd slot of row 0
//     -> that byte = 00, underflow=1 and stays set.
//     -> Next start clears it; timing is unchanged (still 60 clk).
//  3. start pulsed again at cycle 20 of a frame
//     -> ignored: one frame_done only; s_ready strobe count = 8.
//  4. reset asserted mid-ACTIVE
//     -> next cycle all outputs 0, busy=0.
//     -> A later start gives a full, correct frame.
//  5. CONTINUOUS=1, one start
//     -> frame_done every 60 clk; vsync re-rises the cycle after frame_done; busy stays 1.
//  6. With DVP_TX_TEST_PATTERN_EN, tp_sel=1
//     -> bytes 00,01,02,03 / 04..07; s_ready never 1; underflow 0.

Source files
------------

// File: rtl/dvp_frame_tx_if.sv
// Pixel-source stream plus DVP camera pins for dvp_frame_tx.
// master = the transmitter, slave = source/receiver side.
interface dvp_frame_tx_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       cam_pclk;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_dat;

    modport master (
        input  s_data, s_valid,
        output s_ready, cam_pclk, cam_vsync, cam_href, cam_dat
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, cam_pclk, cam_vsync, cam_href, cam_dat
    );
endinterface

// File: rtl/dvp_frame_tx.sv
// Camera-side DVP transmitter: frames a valid/ready byte stream onto pclk/vsync/href/data.
// Build macro DVP_TX_TEST_PATTERN_EN adds tp_sel and a per-frame counting test pattern.
module dvp_frame_tx #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 160,
    parameter int H_BLANK     = 16,
    parameter int ROWS        = 120,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic           tp_sel,
`endif
    dvp_frame_tx_if.master bus,
    output logic           busy,
    output logic           underflow,
    output logic           frame_done
);
    localparam int LINE      = H_ACTIVE + H_BLANK;
    localparam int PH_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int COL_W     = (LINE > 2) ? $clog2(LINE) : 1;
    localparam int MAX_VA    = (VSYNC_LINES > ROWS) ? VSYNC_LINES : ROWS;
    localparam int MAX_BF    = (V_BACK > V_FRONT) ? V_BACK : V_FRONT;
    localparam int MAX_LINES = (MAX_VA > MAX_BF) ? MAX_VA : MAX_BF;
    localparam int ROW_W     = (MAX_LINES > 2) ? $clog2(MAX_LINES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
    } state_t;

    state_t             state, state_nxt;
    logic [PH_W-1:0]    phase;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row, last_row;
    logic               accept, period_end, line_end, state_end, frame_end;
    logic               vsync_lvl, href_slot, fetch, tp_mode;
    logic [7:0]         tp_cnt;
    logic               pclk_q, vsync_q, href_q, busy_q, underflow_q, done_q;
    logic [7:0]         dat_q;

    // busy stays high through the frame_done cycle, so a start there is dropped.
    assign accept     = start && !busy_q;
    assign period_end = (phase == PH_W'(CLK_DIV - 1));
    assign line_end   = period_end && (col == COL_W'(LINE - 1));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept)    state_nxt = ST_VSYNC;
            ST_VSYNC:  if (state_end) state_nxt = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
            ST_VBACK:  if (state_end) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (state_end) state_nxt = (V_FRONT > 0) ? ST_VFRONT :
                                                  (CONTINUOUS ? ST_VSYNC : ST_IDLE);
            ST_VFRONT: if (state_end) state_nxt = CONTINUOUS ? ST_VSYNC : ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        last_row  = '0;
        vsync_lvl = 1'b0;
        href_slot = 1'b0;
        case (state)
            ST_VSYNC: begin
                last_row  = ROW_W'(VSYNC_LINES - 1);
                vsync_lvl = 1'b1;
            end
            ST_VBACK:  last_row = ROW_W'(V_BACK - 1);
            ST_ACTIVE: begin
                last_row  = ROW_W'(ROWS - 1);
                href_slot = ({1'b0, col} < (COL_W + 1)'(H_ACTIVE));
            end
            ST_VFRONT: last_row = ROW_W'(V_FRONT - 1);
            default:   ;
        endcase
        state_end = line_end && (row == last_row);
        frame_end = state_end && ((state == ST_VFRONT) || ((state == ST_ACTIVE) && (V_FRONT == 0)));
        fetch     = href_slot && (phase == '0);
    end

    always_ff @(posedge clk) begin
        if (reset || state == ST_IDLE) begin
            phase <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            phase <= period_end ? '0 : phase + PH_W'(1);
            if (period_end) col <= line_end  ? '0 : col + COL_W'(1);
            if (line_end)   row <= state_end ? '0 : row + ROW_W'(1);
        end
    end

`ifdef DVP_TX_TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (reset)       tp_mode <= 1'b0;
        else if (accept) tp_mode <= tp_sel;
    end
`else
    assign tp_mode = 1'b0;
`endif

    // Pins are loaded from the position counters one cycle later, so data moves with pclk falling.
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_q      <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
            tp_cnt      <= '0;
        end else begin
            pclk_q <= (state != ST_IDLE) && (phase >= PH_W'(CLK_DIV / 2));
            done_q <= frame_end;

            if (accept)                        busy_q <= 1'b1;
            else if (done_q && !CONTINUOUS)    busy_q <= 1'b0;

            if (accept)                                underflow_q <= 1'b0;
            else if (fetch && !tp_mode && !bus.s_valid) underflow_q <= 1'b1;

            if (state == ST_IDLE) begin
                vsync_q <= 1'b0;
                href_q  <= 1'b0;
                dat_q   <= '0;
            end else if (phase == '0) begin
                vsync_q <= vsync_lvl;
                href_q  <= href_slot;
                if (!fetch)       dat_q <= '0;
                else if (tp_mode) dat_q <= tp_cnt;
                else              dat_q <= bus.s_valid ? bus.s_data : 8'h00;
            end

            if (state == ST_VSYNC) tp_cnt <= '0;
            else if (fetch)        tp_cnt <= tp_cnt + 8'd1;
        end
    end

    assign bus.s_ready   = fetch && !tp_mode;
    assign bus.cam_pclk  = pclk_q;
    assign bus.cam_vsync = vsync_q;
    assign bus.cam_href  = href_q;
    assign bus.cam_dat   = dat_q;
    assign busy          = busy_q;
    assign underflow     = underflow_q;
    assign frame_done    = done_q;
endmodule

// File: tb/tb_dvp_frame_tx.sv
// Scoreboard bench for dvp_frame_tx: expected bytes queued per frame, checked on each pclk rise with href high.
// A second instance with CONTINUOUS=1 covers back-to-back framing.
module tb_dvp_frame_tx;
    logic clk = 1'b0;
    logic reset, start, c_start;
    logic busy, underflow, frame_done;
    logic c_busy, c_underflow, c_frame_done;
`ifdef DVP_TX_TEST_PATTERN_EN
    logic tp_sel;
    logic c_tp_sel;
`endif

    dvp_frame_tx_if bus ();
    dvp_frame_tx_if cbus ();

    dvp_frame_tx #(
        .CLK_DIV(2), .H_ACTIVE(4), .H_BLANK(2), .ROWS(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CONTINUOUS(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef DVP_TX_TEST_PATTERN_EN
        .tp_sel(tp_sel),
`endif
        .bus(bus), .busy(busy), .underflow(underflow), .frame_done(frame_done)
    );

    dvp_frame_tx #(
        .CLK_DIV(2), .H_ACTIVE(4), .H_BLANK(2), .ROWS(2),
        .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1), .CONTINUOUS(1'b1)
    ) dut_c (
        .clk(clk), .reset(reset), .start(c_start),
`ifdef DVP_TX_TEST_PATTERN_EN
        .tp_sel(c_tp_sel),
`endif
        .bus(cbus), .busy(c_busy), .underflow(c_underflow), .frame_done(c_frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] exp_q[$];

    // Source: serves A0, A1, ... from the frame's base; one slot may be withheld.
    int strobes = 0, consumed = 0;
    int strobe_base = 0, cons_base = 0, drop_slot = -1;
    bit src_en = 1'b1;
    initial begin
        bus.s_data  = 8'hA0;
        bus.s_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus.s_valid = src_en && ((strobes - strobe_base) != drop_slot);
            bus.s_data  = 8'(32'hA0 + consumed - cons_base);
            if (bus.s_ready) begin
                strobes++;
                if (bus.s_valid) consumed++;
            end
        end
    end

    int vsync_total = 0, href_total = 0, done_total = 0, dat_bad = 0;
    logic pclk_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.cam_vsync) vsync_total++;
        if (bus.cam_href)  href_total++;
        if (frame_done)    done_total++;
        if (!bus.cam_href && bus.cam_dat != 8'h00) dat_bad++;
        if (bus.cam_pclk && !pclk_prev && bus.cam_href) begin
            if (exp_q.size() == 0) check("sb_unexpected_byte", {24'd0, bus.cam_dat}, 32'hFFFF_FFFF);
            else                   check("sb_cam_dat", {24'd0, bus.cam_dat}, {24'd0, exp_q.pop_front()});
        end
        pclk_prev = bus.cam_pclk;
    end

    int c_done_at[4];
    int c_done_n = 0, c_vs_ok = 0, c_busy_low = 0;
    logic c_done_prev = 1'b0;
    always @(negedge clk) begin
        if (c_done_prev && cbus.cam_vsync) c_vs_ok++;
        if (c_frame_done) begin
            if (c_done_n < 4) c_done_at[c_done_n] = cyc;
            c_done_n++;
        end
        if (c_done_n > 0 && !c_busy) c_busy_low++;
        c_done_prev = c_frame_done;
    end

    task automatic push_seq(input logic [7:0] first, input int drop);
        logic [7:0] v;
        v = first;
        for (int i = 0; i < 8; i++) begin
            if (i == drop) exp_q.push_back(8'h00);
            else begin
                exp_q.push_back(v);
                v++;
            end
        end
    endtask

    // Entered and left on a negedge; the start cycle is cycle 0 of the frame.
    task automatic run_frame(input string name, input int drop, input int exp_strobes,
                             input bit exp_uf, input bit extra_start);
        int n, acc, v_base, h_base, d_base, b_base;
        drop_slot   = drop;
        strobe_base = strobes;
        cons_base   = consumed;
        v_base = vsync_total; h_base = href_total; d_base = done_total; b_base = dat_bad;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        check({name, "_busy_rise"}, busy, 1);
        check({name, "_uf_clear"}, underflow, 0);
        n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
            start = (extra_start && n == 20);
        end
        check({name, "_done_seen"}, frame_done, 1);
        check({name, "_done_latency"}, cyc - acc, 60);
        start = extra_start;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_fall"}, busy, 0);
        repeat (70) @(negedge clk);
        check({name, "_vsync_cycles"}, vsync_total - v_base, 12);
        check({name, "_href_cycles"}, href_total - h_base, 16);
        check({name, "_strobes"}, strobes - strobe_base, exp_strobes);
        check({name, "_done_count"}, done_total - d_base, 1);
        check({name, "_dat_zero_outside_href"}, dat_bad - b_base, 0);
        check({name, "_sb_drained"}, exp_q.size(), 0);
        check({name, "_underflow"}, underflow, exp_uf);
        check({name, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; c_start = 1'b0;
`ifdef DVP_TX_TEST_PATTERN_EN
        tp_sel = 1'b0; c_tp_sel = 1'b0;
`endif
        cbus.s_data = 8'h5A; cbus.s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {bus.cam_pclk, bus.cam_vsync, bus.cam_href, bus.cam_dat, bus.s_ready, busy, underflow, frame_done}, 0);
        check("reset_outputs_c", {cbus.cam_pclk, cbus.cam_vsync, cbus.cam_href, c_busy, c_frame_done}, 0);
        reset = 1'b0;
        @(negedge clk);

        push_seq(8'hA0, -1);
        run_frame("t1_basic", -1, 8, 1'b0, 1'b0);

        push_seq(8'hA0, 2);
        run_frame("t2_underflow", 2, 8, 1'b1, 1'b0);

        push_seq(8'hA0, -1);
        run_frame("t2_clear", -1, 8, 1'b0, 1'b0);

        push_seq(8'hA0, -1);
        run_frame("t3_start_busy", -1, 8, 1'b0, 1'b1);

        // Abort a frame mid-ACTIVE and confirm a clean restart.
        push_seq(8'hA0, -1);
        strobe_base = strobes; cons_base = consumed; drop_slot = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.cam_href && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_href_seen", bus.cam_href, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t4_outputs_zero",
              {bus.cam_pclk, bus.cam_vsync, bus.cam_href, bus.cam_dat, bus.s_ready, busy, underflow, frame_done}, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) @(negedge clk);
        push_seq(8'hA0, -1);
        run_frame("t4_after_reset", -1, 8, 1'b0, 1'b0);

`ifdef DVP_TX_TEST_PATTERN_EN
        tp_sel = 1'b1;
        src_en = 1'b0;
        push_seq(8'h00, -1);
        run_frame("t6_pattern", -1, 0, 1'b0, 1'b0);
        tp_sel = 1'b0;
        src_en = 1'b1;
`endif

        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        n = 0;
        while (c_done_n < 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5_three_frames", (c_done_n >= 3), 1);
        repeat (2) @(negedge clk);
        check("t5_period_1", c_done_at[1] - c_done_at[0], 60);
        check("t5_period_2", c_done_at[2] - c_done_at[1], 60);
        check("t5_vsync_rerise", c_vs_ok, 3);
        check("t5_busy_held", c_busy_low, 0);
        check("t5_busy", c_busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
